uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx_if.sv | 11 +
 rtl/uart_tx.sv | 124 ++++++++++++
 tb/tb_uart_tx.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Byte-in / serial-out handshake bundle for uart_tx.
// master: the byte source. slave: the transmitter.
interface uart_tx_if;
    logic [7:0] data;
    logic       start;
    logic       ready;
    logic       tx;

    modport master (output data, output start, input ready, input tx);
    modport slave  (input data, input start, output ready, output tx);
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter; each serial bit is held for BAUD clocks.
// Define UART_TX_START_EDGE_EN to launch on a rising edge of start instead of its level.
module uart_tx #(
    parameter int unsigned BAUD = 434
) (
    input  logic      clk,
    input  logic      rst,
    uart_tx_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [17:0] BAUD_LAST = 18'(BAUD - 1);

    state_t      state_q, state_d;
    logic [17:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        launch;
    logic        bit_done;

`ifdef UART_TX_START_EDGE_EN
    logic start_q, start_d;
    assign start_d = bus.start;
    assign launch  = (state_q == IDLE) && bus.start && !start_q;
`else
    assign launch  = (state_q == IDLE) && bus.start;
`endif

    assign bit_done = (baud_cnt_q == BAUD_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
`ifdef UART_TX_START_EDGE_EN
            start_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
`ifdef UART_TX_START_EDGE_EN
            start_q    <= start_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (launch)                       state_d = START;
            START: if (bit_done)                     state_d = DATA;
            DATA:  if (bit_done && bit_idx_q == 3'd7) state_d = STOP;
            STOP:  if (bit_done)                     state_d = IDLE;
            default:                                 state_d = IDLE;
        endcase
    end

    // The counter restarts at every bit boundary, so bit lengths never accumulate error.
    always_comb begin
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        case (state_q)
            IDLE: begin
                baud_cnt_d = '0;
                bit_idx_d  = '0;
                tx_d       = 1'b1;
                if (launch) begin
                    shift_d = bus.data;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bit_done) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    tx_d       = shift_q[0];
                    shift_d    = shift_q >> 1;
                end else begin
                    baud_cnt_d = baud_cnt_q + 18'd1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    baud_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        tx_d = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 18'd1;
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (bit_done) begin
                    baud_cnt_d = '0;
                end else begin
                    baud_cnt_d = baud_cnt_q + 18'd1;
                end
            end
            default: begin
                baud_cnt_d = '0;
                tx_d       = 1'b1;
            end
        endcase
    end

    assign bus.ready = (state_q == IDLE);
    assign bus.tx    = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed + randomized bench for uart_tx: a BAUD=4 instance for frame detail
// and a default-BAUD instance for full-length timing.
module tb_uart_tx;

    localparam int B   = 4;
    localparam int BIG = 434;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    uart_tx_if bus4 ();
    uart_tx_if bus_big ();

    uart_tx #(.BAUD(B)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    uart_tx u_dut_big (
        .clk (clk),
        .rst (rst),
        .bus (bus_big)
    );

    // Expected line level k clocks into a frame: start 0, data LSB first, stop 1.
    function automatic logic expBit(input logic [7:0] d, input int k, input int baud);
        int i;
        i = k / baud;
        if (i == 0) return 1'b0;
        if (i >= 9) return 1'b1;
        return d[i-1];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] d);
        bus4.data  = d;
        bus4.start = 1'b1;
        @(negedge clk);
    endtask

    // mode 0: drop start at once; 1: wiggle start/data mid-frame; 2: hold start high
    task automatic runFrame(input logic [7:0] d, input int mode, input int ncyc);
        for (int k = 0; k < ncyc; k++) begin
            checkOutput($sformatf("tx[%02h] c%0d", d, k), 32'(bus4.tx), 32'(expBit(d, k, B)));
            checkOutput($sformatf("ready busy c%0d", k), 32'(bus4.ready), 32'd0);
            case (mode)
                0: begin
                    bus4.start = 1'b0;
                    bus4.data  = 8'($urandom);
                end
                1: begin
                    bus4.data  = 8'($urandom);
                    bus4.start = (k < 38) ? 1'($urandom_range(0, 1)) : 1'b0;
                end
                default: ;
            endcase
            @(negedge clk);
        end
    endtask

    task automatic checkIdle(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            checkOutput($sformatf("%s tx c%0d", tag, k), 32'(bus4.tx), 32'd1);
            checkOutput($sformatf("%s ready c%0d", tag, k), 32'(bus4.ready), 32'd1);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [7:0] d;
        int         k;
        int         start_len;

        bus4.data     = 8'h00;
        bus4.start    = 1'b0;
        bus_big.data  = 8'h00;
        bus_big.start = 1'b0;
        rst = 1'b1;
        #2 rst = 1'b0;
        #10;
        checkOutput("reset tx", 32'(bus4.tx), 32'd1);
        checkOutput("reset ready", 32'(bus4.ready), 32'd1);
        checkOutput("reset big tx", 32'(bus_big.tx), 32'd1);
        checkOutput("reset big ready", 32'(bus_big.ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkIdle(3, "idle");

        $display("[TB] single frame 8'hA5");
        applyStimulus(8'hA5);
        runFrame(8'hA5, 0, 40);
        checkIdle(2, "after A5");

        $display("[TB] random frames");
        repeat (4) begin
            d = 8'($urandom);
            applyStimulus(d);
            runFrame(d, 0, 40);
            checkIdle(1, "after rand");
        end

        $display("[TB] mid-frame data/start changes ignored");
        applyStimulus(8'h0A);
        runFrame(8'h0A, 1, 40);
        checkIdle(3, "after 0A");
        repeat (2) begin
            d = 8'($urandom);
            applyStimulus(d);
            runFrame(d, 1, 40);
            checkIdle(2, "after wiggle");
        end

        $display("[TB] start held high with 8'h55");
        applyStimulus(8'h55);
        runFrame(8'h55, 2, 40);
`ifdef UART_TX_START_EDGE_EN
        checkIdle(6, "held edge");
        bus4.start = 1'b0;
        checkIdle(1, "held edge end");
`else
        checkIdle(1, "gap");
        runFrame(8'h55, 0, 40);
        checkIdle(2, "after b2b");
`endif

        $display("[TB] reset mid-frame");
        d = 8'($urandom);
        applyStimulus(d);
        runFrame(d, 0, 17);
        #2 rst = 1'b0;
        #1;
        checkOutput("midreset tx", 32'(bus4.tx), 32'd1);
        checkOutput("midreset ready", 32'(bus4.ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkIdle(1, "post reset");
        applyStimulus(8'h00);
        runFrame(8'h00, 0, 40);
        checkIdle(1, "after 00");

        $display("[TB] default BAUD frame 8'h41");
        bus_big.data  = 8'h41;
        bus_big.start = 1'b1;
        @(negedge clk);
        bus_big.start = 1'b0;
        k = 0;
        start_len = -1;
        while (bus_big.ready == 1'b0 && k < 5000) begin
            if (start_len < 0 && bus_big.tx == 1'b1) start_len = k;
            if (k % BIG == BIG / 2)
                checkOutput($sformatf("big tx bit%0d", k / BIG), 32'(bus_big.tx), 32'(expBit(8'h41, k, BIG)));
            @(negedge clk);
            k++;
        end
        checkOutput("big start bit len", 32'(start_len), 32'(BIG));
        checkOutput("big frame len", 32'(k), 32'(10 * BIG));
        checkOutput("big idle tx", 32'(bus_big.tx), 32'd1);
        checkOutput("big idle ready", 32'(bus_big.ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
